rggen_apb_register_bridge: RTL

RGGEN_APB_REGISTER_BRIDGE -- requirements
Module: rggen_apb_register_bridge

---
 rtl/rggen_apb_register_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rggen_apb_register_bridge.sv
// APB4 slave to rggen register-bus bridge: latches a setup phase, issues a
// one-cycle register command, waits for ready (with timeout) and returns one APB response.
module rggen_apb_register_bridge #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int REGISTERS     = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic                      i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic [3:0]                i_pstrb,
    input  logic [31:0]               i_pwdata,
    output logic                      o_pready,
    output logic [31:0]               o_prdata,
    output logic                      o_pslverr,
    output logic                      o_register_valid,
    output logic                      o_register_write,
    output logic [ADDRESS_WIDTH-1:0]  o_register_address,
    output logic [31:0]               o_register_write_data,
    output logic [31:0]               o_register_strobe,
    input  logic [REGISTERS-1:0]      i_register_active,
    input  logic [REGISTERS-1:0]      i_register_ready,
    input  logic [REGISTERS-1:0]      i_register_error,
    input  logic [32*REGISTERS-1:0]   i_register_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_WAIT,
        ST_RESPONSE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~ADDRESS_WIDTH'(3);

    state_t                     state;
    state_t                     state_next;
    logic [7:0]                 count;
    logic [7:0]                 count_next;
    logic                       write_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [31:0]                wdata_q;
    logic [31:0]                strobe_q;
    logic [31:0]                prdata_q;
    logic                       pslverr_q;

    logic                       setup;
    logic [REGISTERS-1:0]       hit;
    logic [31:0]                hit_data;
    logic [31:0]                strobe_in;
    logic                       resp_load;
    logic                       resp_error;
    logic [31:0]                resp_data;

    assign setup = (state == ST_IDLE) && i_psel && !i_penable;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        strobe_in = '1;
        if (i_pwrite) begin
            for (int i = 0; i < 4; i++) begin
                strobe_in[8*i +: 8] = {8{i_pstrb[i]}};
            end
        end
    end

    // Ready hits from several registers are merged with no priority.
    always_comb begin
        hit      = i_register_active & i_register_ready;
        hit_data = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (hit[k]) begin
                hit_data = hit_data | i_register_read_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = '0;
        resp_load  = 1'b0;
        resp_error = 1'b0;
        resp_data  = '0;
        case (state)
            ST_IDLE: begin
                if (setup) state_next = ST_COMMAND;
            end
            ST_COMMAND, ST_WAIT: begin
                if (hit != '0) begin
                    state_next = ST_RESPONSE;
                    resp_load  = 1'b1;
                    resp_error = |(hit & i_register_error);
                    resp_data  = write_q ? 32'h0 : hit_data;
                end else if (state == ST_COMMAND && i_register_active == '0) begin
                    state_next = ST_RESPONSE;
                    resp_load  = 1'b1;
                    resp_error = 1'b1;
                end else if (state == ST_COMMAND) begin
                    state_next = ST_WAIT;
                end else if (count == WAIT_LAST) begin
                    state_next = ST_RESPONSE;
                    resp_load  = 1'b1;
                    resp_error = 1'b1;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            ST_RESPONSE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (resp_load) begin
                prdata_q  <= resp_data;
                pslverr_q <= resp_error;
            end
        end
    end

    // Command fields stay stable until the next accepted setup phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            strobe_q  <= '0;
        end else if (setup) begin
            write_q   <= i_pwrite;
            address_q <= i_paddr & WORD_MASK;
            wdata_q   <= i_pwdata;
            strobe_q  <= strobe_in;
        end
    end

    assign o_register_valid      = (state == ST_COMMAND);
    assign o_register_write      = write_q;
    assign o_register_address    = address_q;
    assign o_register_write_data = wdata_q;
    assign o_register_strobe     = strobe_q;
    assign o_pready              = (state == ST_RESPONSE);
    assign o_prdata              = o_pready ? prdata_q : 32'h0;
    assign o_pslverr             = o_pready && pslverr_q;

endmodule
